// File: rtl/ov7670_cfg_pkg.sv
// ov7670_cfg_pkg
// Shared definitions for the OV7670 register-table configuration sequencer:
// sequencer state encoding, table marker words and ROM address width.
// Optional feature macro: OV7670_CFG_RETRY_EN (adds the ERROR state).
package ov7670_cfg_pkg;

    localparam int          ADDR_W     = 8;
    localparam logic [15:0] END_MARK   = 16'hFFFF;
    localparam logic [15:0] DELAY_MARK = 16'hFFF0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_WAIT_WR,
        S_DELAY,
`ifdef OV7670_CFG_RETRY_EN
        S_DONE,
        S_ERROR
`else
        S_DONE
`endif
    } cfg_state_t;

endpackage

// File: rtl/cfg_delay_timer.sv
// cfg_delay_timer
// Down-counter used for table delay entries.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (counter cleared)
//   load   - load the counter with CYCLES
//   expire - high during the last cycle of a CYCLES-long interval
// CYCLES must be at least 1.
module cfg_delay_timer #(
    parameter int CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);
    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Counter holds CYCLES in the first interval cycle, so reaching 1 marks
    // the final cycle; the caller leaves its wait state on that edge.
    assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/ov7670_config_seq.sv
// ov7670_config_seq
// Walks a registered register-table ROM and issues SCCB writes for each
// {reg, value} entry. 16'hFFF0 inserts a DELAY_CYCLES pause, 16'hFFFF ends
// the pass. The table never wraps past address 255.
// Optional feature macro: OV7670_CFG_RETRY_EN -- on NACK the same write is
// repeated up to MAX_RETRY extra times, then the sequencer stops in ERROR.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   start                - pulse, begins a pass from IDLE/DONE/ERROR
//   rom_addr, rom_dout   - ROM address out, ROM word in (1 clk latency)
//   cmd_valid/ready      - SCCB write request handshake
//   cmd_reg, cmd_data    - register address / value of the request
//   wr_done, wr_nack     - write completion pulse and NACK status
//   busy, done, error    - status levels
module ov7670_config_seq
    import ov7670_cfg_pkg::*;
#(
    parameter int DELAY_CYCLES = 250000,
    parameter int MAX_RETRY    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_dout,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [7:0]        cmd_reg,
    output logic [7:0]        cmd_data,
    input  logic              wr_done,
    input  logic              wr_nack,
    output logic              busy,
    output logic              done,
    output logic              error
);
    cfg_state_t        state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        reg_nxt, data_nxt;
    logic              fetch_q, fetch_nxt;
    logic              timer_load, timer_expire;
    logic              adv;

`ifdef OV7670_CFG_RETRY_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_q, retry_nxt;
`else
    localparam int UNUSED_MAX_RETRY = MAX_RETRY;
    logic unused_nack;
    assign unused_nack = wr_nack;
`endif

    cfg_delay_timer #(
        .CYCLES (DELAY_CYCLES)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rom_addr <= '0;
            cmd_reg  <= '0;
            cmd_data <= '0;
            fetch_q  <= 1'b0;
`ifdef OV7670_CFG_RETRY_EN
            retry_q  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            rom_addr <= addr_nxt;
            cmd_reg  <= reg_nxt;
            cmd_data <= data_nxt;
            fetch_q  <= fetch_nxt;
`ifdef OV7670_CFG_RETRY_EN
            retry_q  <= retry_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = rom_addr;
        reg_nxt    = cmd_reg;
        data_nxt   = cmd_data;
        fetch_nxt  = 1'b0;
        timer_load = 1'b0;
        adv        = 1'b0;
`ifdef OV7670_CFG_RETRY_EN
        retry_nxt  = retry_q;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_nxt  = '0;
                    state_nxt = S_FETCH;
                end
            end
`ifdef OV7670_CFG_RETRY_EN
            S_ERROR: begin
                if (start) begin
                    addr_nxt  = '0;
                    retry_nxt = '0;
                    state_nxt = S_FETCH;
                end
            end
`endif
            // First FETCH cycle presents the address, second lets the ROM
            // register its output.
            S_FETCH: begin
                if (fetch_q) begin
                    state_nxt = S_DECODE;
                end else begin
                    fetch_nxt = 1'b1;
                end
            end
            S_DECODE: begin
                if (rom_dout == END_MARK) begin
                    state_nxt = S_DONE;
                end else if (rom_dout == DELAY_MARK) begin
                    timer_load = 1'b1;
                    state_nxt  = S_DELAY;
                end else begin
                    reg_nxt   = rom_dout[15:8];
                    data_nxt  = rom_dout[7:0];
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cmd_ready) begin
                    state_nxt = S_WAIT_WR;
                end
            end
            S_WAIT_WR: begin
                if (wr_done) begin
`ifdef OV7670_CFG_RETRY_EN
                    if (wr_nack) begin
                        if (retry_q == RW'(MAX_RETRY)) begin
                            state_nxt = S_ERROR;
                        end else begin
                            retry_nxt = retry_q + RW'(1);
                            state_nxt = S_WRITE;
                        end
                    end else begin
                        adv = 1'b1;
                    end
`else
                    adv = 1'b1;
`endif
                end
            end
            S_DELAY: begin
                if (timer_expire) begin
                    adv = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Entry advance; the last table slot ends the pass instead of wrapping.
        if (adv) begin
`ifdef OV7670_CFG_RETRY_EN
            retry_nxt = '0;
`endif
            if (rom_addr == {ADDR_W{1'b1}}) begin
                state_nxt = S_DONE;
            end else begin
                addr_nxt  = rom_addr + ADDR_W'(1);
                state_nxt = S_FETCH;
            end
        end
    end

    assign cmd_valid = (state == S_WRITE);
    assign done      = (state == S_DONE);
`ifdef OV7670_CFG_RETRY_EN
    assign error     = (state == S_ERROR);
    assign busy      = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
`else
    assign error     = 1'b0;
    assign busy      = !((state == S_IDLE) || (state == S_DONE));
`endif

endmodule

// File: doc/ov7670_config_seq.md
OV7670_CONFIG_SEQ -- requirements
Module: ov7670_config_seq

Interface
REQ-001 Parameter DELAY_CYCLES, 250000, clk cycles per delay entry (10 ms at 25 MHz).
REQ-002 Parameter MAX_RETRY, 3, extra write attempts per entry; used only with OV7670_CFG_RETRY_EN.
REQ-003 Port clk  input  1  sole clock; all logic rising-edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port start  input  1  single-cycle pulse that begins a configuration pass.
REQ-006 Port rom_addr  output  8  address to the register-table ROM.
REQ-007 Port rom_dout  input  16  table word {reg[15:8], value[7:0]}; valid 1 clk after rom_addr changes (registered ROM).
REQ-008 Port cmd_valid  output  1  SCCB write request.
REQ-009 Port cmd_ready  input  1  SCCB master accepts request.
REQ-010 Port cmd_reg  output  8  register address for the write.
REQ-011 Port cmd_data  output  8  register value for the write.
REQ-012 Port wr_done  input  1  single-cycle pulse when the SCCB write completes.
REQ-013 Port wr_nack  input  1  NACK status, sampled only when wr_done=1.
REQ-014 Port busy  output  1  high in every state except IDLE, DONE, ERROR.
REQ-015 Port done  output  1  level, high in DONE.
REQ-016 Port error  output  1  level, high in ERROR; tied 0 without OV7670_CFG_RETRY_EN.

Function
REQ-017 States: IDLE, FETCH, DECODE, WRITE, WAIT_WR, DELAY, DONE, ERROR (ERROR only with macro).
REQ-018 IDLE/DONE/ERROR + start=1 -> rom_addr=0, FETCH; start in any other state ignored.
REQ-019 FETCH lasts exactly 2 clks (addr to ROM, ROM register), then DECODE.
REQ-020 DECODE: rom_dout=16'hFFFF -> DONE; 16'hFFF0 -> DELAY with counter loaded; else latch cmd_reg/cmd_data, enter WRITE.
REQ-021 WRITE: cmd_valid=1, cmd_reg/cmd_data stable until cmd_ready=1 sampled; same cycle cmd_valid drops, go WAIT_WR.
REQ-022 WAIT_WR: on wr_done=1 (and no NACK retry per REQ-031), advance entry.
REQ-023 DELAY: exactly DELAY_CYCLES clks, then advance entry.
REQ-024 Advance entry: rom_addr=rom_addr+1, FETCH; if rom_addr=255, go DONE instead (no wrap).
REQ-025 wr_done outside WAIT_WR ignored; cmd_ready while cmd_valid=0 ignored.
REQ-026 Minimum per-entry latency: 2 FETCH + 1 DECODE + 1 WRITE + WAIT_WR duration.

Reset
REQ-027 rst_n=0 forces immediately, without clk: state=IDLE, rom_addr=0, cmd_valid=0, cmd_reg=0, cmd_data=0, busy=0, done=0, error=0, delay counter=0, retry counter=0.
REQ-028 Reset mid-operation abandons the pass; no write resumes after rst_n rises until a new start.
REQ-029 Outputs driven from registers only; no combinational path from inputs to outputs.

Configuration
REQ-030 Macro OV7670_CFG_RETRY_EN selects NACK retry.
REQ-031 Defined: wr_done with wr_nack=1 returns to WRITE with same reg/value and increments retry counter; after MAX_RETRY retries a further NACK -> ERROR; retry counter clears on each entry advance.
REQ-032 Not defined: wr_nack ignored, no ERROR state, error=0, retry logic absent.

Structure
REQ-033 Package ov7670_cfg_pkg holds the state enum, END_MARK=16'hFFFF, DELAY_MARK=16'hFFF0, address width 8.
REQ-034 Sub-module cfg_delay_timer (load, count-down, expire pulse) implements DELAY; it is the only sub-module.

Verification
REQ-035 ROM {0:1280,1:FFF0,2:1204,3:FFFF}, cmd_ready/wr_done after 3 clks -> writes (12,80),(12,04) in order, DELAY_CYCLES gap between them, done=1, busy=0.
REQ-036 cmd_ready held low 20 clks -> cmd_valid, cmd_reg, cmd_data stable all 20 clks, exactly one write accepted.
REQ-037 rst_n=0 during DELAY at entry 1 -> cmd_valid=0, rom_addr=0 asynchronously; no write until new start, then pass restarts at addr 0.
REQ-038 Table without FFFF, all 256 entries writes -> 256 writes, done at addr 255, rom_addr never wraps.
REQ-039 Macro defined, MAX_RETRY=3, entry 2 always NACKs -> 4 writes of entry 2, error=1, busy=0; macro undefined, same stimulus -> single write, pass continues.
REQ-040 start pulsed while busy -> ignored; start in DONE -> new pass from addr 0, done drops next clk.
